univ_shiftreg: RTL and testbench
================================

UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits, legal values 2..64.
REQ-002 Derived constant: AMT_W, $clog2(WIDTH)+1, width of the shift amount; not overridable.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; accepted only when state is IDLE or DONE.
REQ-006 mode  input  3  operation code, defined in REQ-012.
REQ-007 din  input  WIDTH  operand, captured on the accepting edge.
REQ-008 amt  input  AMT_W  shift count; values above WIDTH clamp to WIDTH.
REQ-009 sin  input  1  serial-in bit, sampled on every shift edge in modes SLI and SRI.
REQ-010 q  output  WIDTH  register contents.
REQ-011 busy / done / sout  output  1 each  busy=1 while shifting; done=1 for exactly one cycle when the operation completes; sout=last bit shifted or rotated out.

Function
REQ-012 mode encoding: 000 LOAD, 001 SLL, 010 SRL, 011 ROL, 100 ROR, 101 SRA, 110 SLI (left, LSB fill from sin), 111 SRI (right, MSB fill from sin).
REQ-013 FSM states: IDLE, SHIFT, DONE; all outputs registered.
REQ-014 On the accepting edge E: q<=din, cnt<=min(amt,WIDTH), and mode is latched; the next state is SHIFT if the count is >0 and mode!=LOAD, else DONE.
REQ-015 LOAD ignores amt and always goes to DONE after one edge.
REQ-016 In SHIFT, each edge performs a 1-bit operation on q per the latched mode and decrements cnt; when cnt==1 the next state is DONE.
REQ-017 Latency: with clamped count n, done=1 in the cycle following edge E+n; n=0 gives done in the cycle after E with q=din.
REQ-018 Fill rules: SLL and SRL fill with 0; SRA fills with q[WIDTH-1]; ROL and ROR recirculate; SLI and SRI insert sin.
REQ-019 sout updates on every shift edge to the exiting bit: q[WIDTH-1] for left ops, q[0] for right ops. It holds its value otherwise, and is not altered by LOAD or by a start.
REQ-020 busy=1 exactly while state==SHIFT.
REQ-021 DONE lasts one cycle, then the FSM goes to IDLE. A start during DONE is accepted as at REQ-014, giving back-to-back operation with no idle cycle.
REQ-022 start is ignored in SHIFT. mode, din and amt changes during SHIFT have no effect.
REQ-023 q holds its value in IDLE and DONE.

Reset
REQ-024 While rst=1 at an edge: state<=IDLE, q<=0, cnt<=0, sout<=0, busy<=0, done<=0.
REQ-025 rst has priority over start and over any in-flight operation; an aborted operation never asserts done.
REQ-026 Operation after rst deasserts is identical to operation from power-on reset.

Structure
REQ-027 Package shiftreg_pkg holds the mode enum typedef (REQ-012 encodings) and the FSM state enum typedef.
REQ-028 The single-bit operation is the combinational sub-module shift_step, with parameter WIDTH, inputs q, mode and sin, and outputs next_q and out_bit. univ_shiftreg instantiates it once.
REQ-029 No other sub-modules are used, and there are no latches or multi-cycle paths.

Verification (WIDTH=8)
REQ-030 din=8'h96, SLL, amt=3 -> q=8'hB0 and sout=0; done asserts in the cycle after edge E+3; busy=1 for 3 cycles.
REQ-031 din=8'hA5, ROR, amt=8 -> q=8'hA5 and sout=1; then SRA with din=8'h80, amt=12 (clamps to 8) -> q=8'hFF, done after 8 shifts.
REQ-032 din=8'h00, SRI, sin=1, amt=4 -> q=8'hF0; then LOAD with din=8'h3C -> q=8'h3C and done in the cycle after E, busy never 1, sout unchanged.
REQ-033 SRL with din=8'hFF, amt=7, and rst=1 on the third shift edge -> next cycle q=0, busy=0, done=0, no done pulse follows; a fresh SLL of 8'h01 with amt=1 then gives q=8'h02.
REQ-034 start pulsed during SHIFT -> ignored, with q and the count unaffected; start held during DONE -> new operation accepted with no idle cycle between done and busy.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package shiftreg_pkg;

    // Operation codes as seen on the mode input.
    typedef enum logic [2:0] {
        MODE_LOAD = 3'b000,
        MODE_SLL  = 3'b001,
        MODE_SRL  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_SRA  = 3'b101,
        MODE_SLI  = 3'b110,
        MODE_SRI  = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Left-moving operations push q[MSB] out; all others push q[0] out.
    function automatic logic is_left(input mode_t m);
        return (m == MODE_SLL) || (m == MODE_ROL) || (m == MODE_SLI);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate of a WIDTH-bit word according to mode.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register next_q/out_bit.
//
// Ports:
//   q       current register contents
//   mode    operation code (mode_t encoding)
//   sin     serial fill bit for SLI/SRI
//   next_q  q after one step (q unchanged for LOAD)
//   out_bit bit leaving the word on this step
module shift_step
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    mode_t w_mode;

    always_comb begin
        w_mode  = mode_t'(mode);
        next_q  = q;
        out_bit = is_left(w_mode) ? q[WIDTH-1] : q[0];
        case (w_mode)
            MODE_SLL: next_q = {q[WIDTH-2:0], 1'b0};
            MODE_SRL: next_q = {1'b0, q[WIDTH-1:1]};
            MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
            MODE_SRA: next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_SLI: next_q = {q[WIDTH-2:0], sin};
            MODE_SRI: next_q = {sin, q[WIDTH-1:1]};
            default:  next_q = q;
        endcase
    end

endmodule

// File: rtl/univ_shiftreg.sv
// Universal shift register: load operand, then shift/rotate it amt times, one bit per clock.
// Latency: done pulses in the cycle after the n-th shift edge (n = min(amt, WIDTH)); n=0 or LOAD -> cycle after accept.
// Backpressure: start is accepted only in IDLE or DONE; it is ignored while busy.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start/mode/din/amt  operation request, captured on the accepting edge
//   sin               serial fill bit sampled on each SLI/SRI shift edge
//   q                 register contents
//   busy/done/sout    shifting flag, one-cycle completion pulse, last bit shifted out
module univ_shiftreg
    import shiftreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             sout
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [AMT_W-1:0] r_cnt;
    mode_t            r_mode;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [AMT_W-1:0] w_cnt_nxt;
    mode_t            w_mode_nxt;
    logic             w_sout_nxt;
    logic             w_accept;
    logic [AMT_W-1:0] w_amt_clamped;
    mode_t            w_mode_in;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (r_q),
        .mode    (r_mode),
        .sin     (sin),
        .next_q  (w_step_q),
        .out_bit (w_step_bit)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_cnt_nxt     = r_cnt;
        w_mode_nxt    = r_mode;
        w_sout_nxt    = r_sout;
        w_mode_in     = mode_t'(mode);
        w_amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;
        // DONE accepts too, so a held start runs operations back to back.
        w_accept      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_q_nxt    = din;
                    w_mode_nxt = w_mode_in;
                    // LOAD discards amt so it can never enter SHIFT.
                    w_cnt_nxt  = (w_mode_in == MODE_LOAD) ? '0 : w_amt_clamped;
                    if ((w_mode_in != MODE_LOAD) && (w_amt_clamped != '0)) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_q_nxt    = w_step_q;
                w_sout_nxt = w_step_bit;
                w_cnt_nxt  = r_cnt - AMT_ONE;
                if (r_cnt == AMT_ONE) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_LOAD;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_sout  <= w_sout_nxt;
            // Flags are registered copies of the next-state decode.
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;
    assign sout = r_sout;

endmodule

// File: tb/tb_univ_shiftreg.sv
module tb_univ_shiftreg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] din = 8'd0;
    logic [3:0] amt = 4'd0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       sout;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    univ_shiftreg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .din   (din),
        .amt   (amt),
        .sin   (sin),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .sout  (sout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An operation is "n shifts remaining"; busy means shifts remain.
    logic [7:0] m_q    = 8'd0;
    logic       m_sout = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_mode = 3'd0;
    int         m_left = 0;

    always @(posedge clk) begin
        int v;
        int n;
        if (rst) begin
            m_q = 8'd0; m_sout = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            v = int'(m_q);
            case (m_mode)
                3'd1: begin m_sout = m_q[7]; v = (v * 2) % 256; end
                3'd2: begin m_sout = m_q[0]; v = v / 2; end
                3'd3: begin m_sout = m_q[7]; v = (v * 2) % 256 + v / 128; end
                3'd4: begin m_sout = m_q[0]; v = v / 2 + (v % 2) * 128; end
                3'd5: begin m_sout = m_q[0]; v = v / 2 + ((v >= 128) ? 128 : 0); end
                3'd6: begin m_sout = m_q[7]; v = (v * 2) % 256 + int'(sin); end
                3'd7: begin m_sout = m_q[0]; v = v / 2 + int'(sin) * 128; end
                default: ;
            endcase
            m_q = 8'(v);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else if (start) begin
            n = (int'(amt) > 8) ? 8 : int'(amt);
            m_q = din;
            m_mode = mode;
            if (mode == 3'd0 || n == 0) begin
                m_left = 0; m_done = 1'b1;
            end else begin
                m_left = n; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_q",    64'(q),    64'(m_q));
            chk("mon_busy", 64'(busy), 64'(m_left > 0));
            chk("mon_done", 64'(done), 64'(m_done));
            chk("mon_sout", 64'(sout), 64'(m_sout));
        end
    end

    // ---------------- directed operations with literal expectations ----------------
    task automatic run_op(input string nm, input logic [2:0] md, input logic [7:0] d,
                          input logic [3:0] a, input logic s, input int exp_lat,
                          input logic [7:0] exp_q, input logic exp_sout);
        int lat;
        int nbusy;
        @(posedge clk); #1;
        start = 1'b1; mode = md; din = d; amt = a; sin = s;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        chk({nm, "_q"}, 64'(q), 64'(exp_q));
        chk({nm, "_sout"}, 64'(sout), 64'(exp_sout));
    endtask

    initial begin
        int k;
        int ndone;

        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("reset_q", 64'(q), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_sout", 64'(sout), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("sll3",   3'b001, 8'h96, 4'd3,  1'b0, 4,  8'hB0, 1'b0);
        run_op("ror8",   3'b100, 8'hA5, 4'd8,  1'b0, 9,  8'hA5, 1'b1);
        run_op("load1",  3'b000, 8'h3C, 4'd5,  1'b0, 1,  8'h3C, 1'b1);
        run_op("sra12",  3'b101, 8'h80, 4'd12, 1'b0, 9,  8'hFF, 1'b1);
        run_op("sri4",   3'b111, 8'h00, 4'd4,  1'b1, 5,  8'hF0, 1'b0);
        run_op("load2",  3'b000, 8'h3C, 4'd0,  1'b0, 1,  8'h3C, 1'b0);
        run_op("sll0",   3'b001, 8'h5A, 4'd0,  1'b0, 1,  8'h5A, 1'b0);
        run_op("sli8",   3'b110, 8'h00, 4'd15, 1'b1, 9,  8'hFF, 1'b0);
        run_op("rol1",   3'b011, 8'h80, 4'd1,  1'b0, 2,  8'h01, 1'b1);

        // Reset on the third shift edge of SRL 0xFF by 7.
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b010; din = 8'hFF; amt = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_q", 64'(q), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'h0);
        run_op("post_rst", 3'b001, 8'h01, 4'd1, 1'b0, 2, 8'h02, 1'b0);

        // Start pulse during SHIFT is ignored.
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b001; din = 8'h01; amt = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; din = 8'hFF; mode = 3'b111;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b000; din = 8'h77; amt = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        chk("ign_start_latency", 64'(k), 64'd3);
        chk("ign_start_q", 64'(q), 64'h20);

        // Start held through DONE: back-to-back operations.
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b011; din = 8'h81; amt = 4'd2;
        @(posedge clk); #1;
        mode = 3'b001; din = 8'h0F; amt = 4'd2;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        chk("b2b_first_q", 64'(q), 64'h06);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_no_gap", 64'(busy), 64'h1);
        k = 0;
        while (k < 40) begin
            if (done) break;
            @(negedge clk);
            k++;
        end
        chk("b2b_second_q", 64'(q), 64'h3C);

        // Randomized traffic, checked cycle by cycle against the model.
        repeat (4000) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            mode  = 3'($urandom_range(0, 7));
            din   = 8'($urandom);
            amt   = 4'($urandom_range(0, 15));
            sin   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
